// File: rtl/sticky_flag_reader_pkg.sv
// Shared types, default parameters and helpers for the sticky flag reader.
package sticky_flag_reader_pkg;

    localparam int N_DEFAULT     = 8;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Number of set bits in a 32-bit vector; flags narrower than 32 are zero-padded by the caller.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sticky_flag_cell.sv
// One sticky flag bit with its lost-event bit; a set pulse always wins over a clear.
module sticky_flag_cell (
    input  logic clk,
    input  logic r_n,
    input  logic set,
    input  logic clr,
    output logic flag,
    output logic lost,
    output logic lost_ev
);

    logic flag_r;
    logic lost_r;

    // Flag and lost storage; a set arriving on an already-set flag is a lost event.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            flag_r <= 1'b0;
            lost_r <= 1'b0;
        end else begin
            flag_r <= set | (flag_r & ~clr);
            lost_r <= (set & flag_r) | (lost_r & ~clr);
        end
    end

    assign flag    = flag_r;
    assign lost    = lost_r;
    assign lost_ev = set & flag_r;

endmodule

// File: rtl/sticky_flag_reader.sv
// Sticky event flags with a valid/ready read port (peek or read-to-clear), lost-event counter and level irq.
// Optional irq mask register and ports are built when STICKY_FLAG_MASK_EN is defined.
module sticky_flag_reader
    import sticky_flag_reader_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic [N-1:0]     set_in,
    input  logic             rd_valid,
    input  logic             rd_clear,
    output logic             rd_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
`ifdef STICKY_FLAG_MASK_EN
    input  logic             mask_wr,
    input  logic [N-1:0]     mask_data,
`endif
    output logic [N-1:0]     rsp_data,
    output logic [N-1:0]     rsp_lost,
    output logic [CNT_W-1:0] lost_cnt,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_r;
    logic             rd_ready_r;
    logic             rsp_valid_r;
    logic [N-1:0]     rsp_data_r;
    logic [N-1:0]     rsp_lost_r;
    logic [CNT_W-1:0] cnt_r;
    logic             irq_r;

    logic [N-1:0]     flags_s;
    logic [N-1:0]     lost_s;
    logic [N-1:0]     lost_ev_s;
    logic             hs_s;
    logic             clr_s;
    logic [31:0]      ev32_s;
    logic [5:0]       ev_cnt_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W+5:0] cnt_sum_s;
    logic [CNT_W-1:0] cnt_next_s;

    assign hs_s  = rd_valid & rd_ready_r;
    assign clr_s = hs_s & rd_clear;

    // Every flag is part of the snapshot, so a read-clear clears all of them; pending sets still win.
    generate
        for (genvar i = 0; i < N; i++) begin : g_cell
            sticky_flag_cell u_cell (
                .clk     (clk),
                .r_n     (r_n),
                .set     (set_in[i]),
                .clr     (clr_s),
                .flag    (flags_s[i]),
                .lost    (lost_s[i]),
                .lost_ev (lost_ev_s[i])
            );
        end
    endgenerate

    // Saturating next value of the lost counter, restarting from zero on a read-clear.
    always_comb begin
        ev32_s          = 32'd0;
        ev32_s[N-1:0]   = lost_ev_s;
        ev_cnt_s        = popcount32(ev32_s);
        if (clr_s) begin
            cnt_base_s = {CNT_W{1'b0}};
        end else begin
            cnt_base_s = cnt_r;
        end
        cnt_sum_s = (CNT_W+6)'(cnt_base_s) + (CNT_W+6)'(ev_cnt_s);
        if (cnt_sum_s > (CNT_W+6)'(CNT_MAX)) begin
            cnt_next_s = CNT_MAX;
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Read FSM with registered handshake outputs and snapshot registers.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_r     <= IDLE;
            rd_ready_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {N{1'b0}};
            rsp_lost_r  <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        state_r     <= RESP;
                        rd_ready_r  <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= flags_s;
                        rsp_lost_r  <= lost_s;
                    end else begin
                        rd_ready_r  <= 1'b1;
                        rsp_valid_r <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rd_ready_r  <= 1'b1;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rd_ready_r  <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rd_ready_r  <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Lost-event counter register.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

`ifdef STICKY_FLAG_MASK_EN
    logic [N-1:0] mask_r;

    // Mask resets to all-masked; it only gates the interrupt, never the stored flags.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            mask_r <= {N{1'b1}};
        end else if (mask_wr) begin
            mask_r <= mask_data;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Registered level interrupt from unmasked flags.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(flags_s & ~mask_r);
        end
    end
`else
    // Registered level interrupt from any set flag.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |flags_s;
        end
    end
`endif

    assign rd_ready  = rd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_lost  = rsp_lost_r;
    assign lost_cnt  = cnt_r;
    assign irq       = irq_r;

endmodule

// File: tb/tb_sticky_flag_reader.sv
// Randomized and directed bench for sticky_flag_reader against a bit-mask reference model.
module tb_sticky_flag_reader;

    localparam int N       = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             r_n = 1'b0;
    logic [N-1:0]     set_in = '0;
    logic             rd_valid = 1'b0;
    logic             rd_clear = 1'b0;
    logic             rd_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [N-1:0]     rsp_data;
    logic [N-1:0]     rsp_lost;
    logic [CNT_W-1:0] lost_cnt;
    logic             irq;
`ifdef STICKY_FLAG_MASK_EN
    logic             mask_wr = 1'b0;
    logic [N-1:0]     mask_data = '0;
    int               m_mask;
`endif

    int total = 0;
    int bad   = 0;

    int m_flags, m_lost, m_cnt, m_rsp_data, m_rsp_lost;
    bit m_busy, m_ready, m_irq;

    sticky_flag_reader #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .r_n       (r_n),
        .set_in    (set_in),
        .rd_valid  (rd_valid),
        .rd_clear  (rd_clear),
        .rd_ready  (rd_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
`ifdef STICKY_FLAG_MASK_EN
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
`endif
        .rsp_data  (rsp_data),
        .rsp_lost  (rsp_lost),
        .lost_cnt  (lost_cnt),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = 0; m_lost = 0; m_cnt = 0; m_rsp_data = 0; m_rsp_lost = 0;
        m_busy = 1'b0; m_ready = 1'b0; m_irq = 1'b0;
`ifdef STICKY_FLAG_MASK_EN
        m_mask = 'hFF;
`endif
    endtask

    task automatic model_step(input int s, input bit v, input bit c, input bit rr);
        int old_f;
        int losses;
        bit hs;
        if (!r_n) begin
            model_reset();
            return;
        end
        old_f  = m_flags;
        losses = $countones(s & old_f);
        hs     = v && m_ready;
`ifdef STICKY_FLAG_MASK_EN
        m_irq = ((old_f & ~m_mask & 'hFF) != 0);
        if (mask_wr) m_mask = int'(mask_data);
`else
        m_irq = (old_f != 0);
`endif
        if (hs) begin
            m_rsp_data = old_f;
            m_rsp_lost = m_lost;
        end
        if (hs && c) begin
            m_flags = s;
            m_lost  = s & old_f;
            m_cnt   = losses;
        end else begin
            m_flags = old_f | s;
            m_lost  = m_lost | (s & old_f);
            m_cnt   = m_cnt + losses;
        end
        if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
        if (hs) m_busy = 1'b1;
        else if (m_busy && rr) m_busy = 1'b0;
        m_ready = !m_busy;
    endtask

    task automatic check_outputs();
        check_eq("rd_ready", rd_ready, m_ready);
        check_eq("rsp_valid", rsp_valid, m_busy);
        check_eq("lost_cnt", lost_cnt, m_cnt);
        check_eq("irq", irq, m_irq);
        if (m_busy) begin
            check_eq("rsp_data", rsp_data, m_rsp_data);
            check_eq("rsp_lost", rsp_lost, m_rsp_lost);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic cycle(input int s, input bit v, input bit c, input bit rr);
        set_in    = s[N-1:0];
        rd_valid  = v;
        rd_clear  = c;
        rsp_ready = rr;
        @(negedge clk);
        check_outputs();
        model_step(s & 'hFF, v, c, rr);
        @(posedge clk);
        #1;
    endtask

`ifdef STICKY_FLAG_MASK_EN
    task automatic mask_write(input int val);
        mask_wr   = 1'b1;
        mask_data = val[N-1:0];
        cycle(0, 1'b0, 1'b0, 1'b1);
        mask_wr   = 1'b0;
    endtask
`endif

    initial begin
        model_reset();

        // reset held with all set pulses active
        repeat (3) cycle('hFF, 1'b1, 1'b1, 1'b1);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_lost", rsp_lost, 0);
        check_eq("rst_irq", irq, 0);
        check_eq("rst_lost_cnt", lost_cnt, 0);
        check_eq("rst_rd_ready", rd_ready, 0);
        r_n = 1'b1;
        cycle(0, 1'b0, 1'b0, 1'b1);
        check_eq("rel_rd_ready", rd_ready, 1);
        cycle(0, 1'b1, 1'b0, 1'b1);
        check_eq("rel_flags_zero", rsp_data, 0);
        cycle(0, 1'b0, 1'b0, 1'b1);

        // set then read-clear, then a second read sees nothing
        cycle('h05, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b1, 1'b1);
        check_eq("rc_valid", rsp_valid, 1);
        check_eq("rc_data", rsp_data, 'h05);
        check_eq("rc_lost", rsp_lost, 0);
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b1, 1'b1);
        check_eq("rc2_data", rsp_data, 0);
        cycle(0, 1'b0, 1'b0, 1'b1);

        // set colliding with a read-clear survives
        cycle('h01, 1'b0, 1'b0, 1'b1);
        cycle('h01, 1'b1, 1'b1, 1'b1);
        check_eq("col_data", rsp_data, 'h01);
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b0, 1'b1);
        check_eq("col_flag_kept", rsp_data, 'h01);
        check_eq("col_lost", rsp_lost, 'h01);
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b1, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);

        // three pulses on flag 3 give two lost events
        repeat (3) begin
            cycle('h08, 1'b0, 1'b0, 1'b1);
            cycle(0, 1'b0, 1'b0, 1'b1);
        end
        check_eq("lost_cnt2", lost_cnt, 2);
        cycle(0, 1'b1, 1'b1, 1'b1);
        check_eq("lost_rsp", rsp_lost, 'h08);
        check_eq("lost_cleared", lost_cnt, 0);
        cycle(0, 1'b0, 1'b0, 1'b1);

        // backpressure holds the snapshot while flags keep changing
        cycle('h30, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(int'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
            check_eq("bp_data", rsp_data, 'h30);
            check_eq("bp_rd_ready", rd_ready, 0);
        end
        cycle(0, 1'b0, 1'b0, 1'b1);

        // irq behaviour from a cleared state
        cycle(0, 1'b1, 1'b1, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);
        check_eq("irq_idle", irq, 0);
`ifdef STICKY_FLAG_MASK_EN
        mask_write('hFE);
        cycle('h02, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);
        check_eq("irq_masked", irq, 0);
        mask_write('hFC);
        cycle(0, 1'b0, 1'b0, 1'b1);
        check_eq("irq_unmasked", irq, 1);
`else
        cycle('h02, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);
        check_eq("irq_set", irq, 1);
`endif

        // lost counter saturation, then read-clear with same-cycle losses
        repeat (40) cycle('hFF, 1'b0, 1'b0, 1'b1);
        check_eq("cnt_sat", lost_cnt, CNT_MAX);
        cycle('hFF, 1'b1, 1'b1, 1'b1);
        check_eq("cnt_clr_losses", lost_cnt, 8);
        cycle(0, 1'b0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
`ifdef STICKY_FLAG_MASK_EN
            mask_wr   = ($urandom_range(0, 15) == 0);
            mask_data = N'($urandom);
`endif
            cycle(int'($urandom & $urandom & 32'hFF), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
        end
`ifdef STICKY_FLAG_MASK_EN
        mask_wr = 1'b0;
`endif

        // async reset while a response is pending
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle('h11, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_valid", rsp_valid, 1);
        #2;
        r_n = 1'b0;
        #1;
        check_eq("arst_valid", rsp_valid, 0);
        check_eq("arst_rd_ready", rd_ready, 0);
        check_eq("arst_data", rsp_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        cycle('hFF, 1'b1, 1'b1, 1'b1);
        r_n = 1'b1;
        repeat (5) cycle(0, 1'b0, 1'b0, 1'b1);
        check_eq("post_rst_no_rsp", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
